// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush controller and EX-stage forwarding selects for a 5-stage MIPS pipeline.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int STALL_CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rt,
  input  logic [4:0]             ex_rs,
  input  logic [4:0]             ex_rt,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_mem_load,
  input  logic [4:0]             mem_rd,
  input  logic                   mem_reg_write,
  input  logic                   mem_access,
  input  logic                   dmem_ready,
  input  logic [4:0]             wb_rd,
  input  logic                   wb_reg_write,
  input  logic                   branch_taken,
  output logic                   pc_we,
  output logic                   ifid_we,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   pipe_freeze,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [STALL_CNT_W-1:0] flush_count,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   wait_w;
  logic   lu_w;
  logic   flush_evt;
  logic   stall_evt;

  assign wait_w = mem_access & ~dmem_ready;
  assign lu_w   = ex_mem_load & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  // MEM_WAIT with dmem_ready high falls through to the RUN priority chain in the same cycle.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    flush_evt   = 1'b0;
    state_d     = state_q;
    if ((state_q == ST_STALL) && !wait_w) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = ST_RUN;
    end else if (wait_w || ((state_q == ST_MEM_WAIT) && !dmem_ready)) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      pipe_freeze = 1'b1;
      state_d     = ST_MEM_WAIT;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_evt   = 1'b1;
      state_d     = ST_RUN;
    end else if (lu_w) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = (LOAD_STALL_CYCLES == 2) ? ST_STALL : ST_RUN;
    end else begin
      state_d     = ST_RUN;
    end
    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_freeze = 1'b0;
      flush_evt   = 1'b0;
    end
  end

  assign stall_evt = rst_n & ~pc_we;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src))
      fwd_sel = 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == src))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  assign fwd_a       = rst_n ? fwd_sel(ex_rs) : 2'b00;
  assign fwd_b       = rst_n ? fwd_sel(ex_rt) : 2'b00;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

`ifdef HAZARD_STATS_EN
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  logic [STALL_CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  logic unused_evt;
  assign unused_evt   = stall_evt ^ flush_evt;
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances (LOAD_STALL_CYCLES=1 and 2) share inputs;
// the driver pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;
  localparam int CW = 16;
  localparam int W  = 2 * (9 + 2 * CW);

  localparam logic [8:0] C_RUN = 9'b11_000_0000;
  localparam logic [8:0] C_LU  = 9'b00_010_0000;
  localparam logic [8:0] C_BR  = 9'b11_110_0000;
  localparam logic [8:0] C_FRZ = 9'b00_001_0000;
  localparam logic [8:0] C_RST = 9'b00_110_0000;
  localparam logic [8:0] FA_M  = 9'b0000_01000;
  localparam logic [8:0] FA_W  = 9'b0000_00100;
  localparam logic [8:0] FB_M  = 9'b0000_00010;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       ex_mem_load;
    logic [4:0] mem_rd;
    logic       mem_reg_write, mem_access, dmem_ready;
    logic [4:0] wb_rd;
    logic       wb_reg_write, branch_taken;
  } stim_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
  logic id_uses_rt = 0, ex_mem_load = 0, mem_reg_write = 0, mem_access = 0, dmem_ready = 1;
  logic wb_reg_write = 0, branch_taken = 0;

  logic pc_we1, ifid_we1, ifid_flush1, idex_bubble1, pipe_freeze1;
  logic pc_we2, ifid_we2, ifid_flush2, idex_bubble2, pipe_freeze2;
  logic [1:0] fwd_a1, fwd_b1, fwd_a2, fwd_b2, dbg1, dbg2;
  logic [CW-1:0] st1, fl1, st2, fl2;

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .STALL_CNT_W(CW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_mem_load(ex_mem_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_access(mem_access),
    .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .pc_we(pc_we1), .ifid_we(ifid_we1),
    .ifid_flush(ifid_flush1), .idex_bubble(idex_bubble1), .pipe_freeze(pipe_freeze1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .stall_cycles(st1), .flush_count(fl1),
    .dbg_state_o(dbg1)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .STALL_CNT_W(CW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_mem_load(ex_mem_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_access(mem_access),
    .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .pc_we(pc_we2), .ifid_we(ifid_we2),
    .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2), .pipe_freeze(pipe_freeze2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_cycles(st2), .flush_count(fl2),
    .dbg_state_o(dbg2)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [CW-1:0] m_st1 = '0, m_fl1 = '0, m_st2 = '0, m_fl2 = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // driver
  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    s.dmem_ready = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s, input logic [8:0] e1, input logic [8:0] e2, input string nm);
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    rst_n = s.rst_n; id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rt = s.id_uses_rt;
    ex_rs = s.ex_rs; ex_rt = s.ex_rt; ex_rd = s.ex_rd; ex_mem_load = s.ex_mem_load;
    mem_rd = s.mem_rd; mem_reg_write = s.mem_reg_write; mem_access = s.mem_access;
    dmem_ready = s.dmem_ready; wb_rd = s.wb_rd; wb_reg_write = s.wb_reg_write;
    branch_taken = s.branch_taken;
    if (!s.rst_n) begin
      m_st1 = '0; m_fl1 = '0; m_st2 = '0; m_fl2 = '0;
    end
`ifdef HAZARD_STATS_EN
    e = {e1, m_st1, m_fl1, e2, m_st2, m_fl2};
`else
    e = {e1, {2*CW{1'b0}}, e2, {2*CW{1'b0}}};
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (s.rst_n) begin
      if (!e1[8]) m_st1++;
      if (!e2[8]) m_st2++;
      if (e1[8] && e1[6]) m_fl1++;
      if (e2[8] && e2[6]) m_fl2++;
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk({nm, " ctrl1"}, 64'({pc_we1, ifid_we1, ifid_flush1, idex_bubble1, pipe_freeze1, fwd_a1, fwd_b1}),
          64'(e[W-1 -: 9]));
      chk({nm, " ctrl2"}, 64'({pc_we2, ifid_we2, ifid_flush2, idex_bubble2, pipe_freeze2, fwd_a2, fwd_b2}),
          64'(e[W/2-1 -: 9]));
      chk({nm, " cnt"}, 64'({st1, fl1, st2, fl2}), 64'({e[W-10 -: 2*CW], e[W/2-10 -: 2*CW]}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    s = idle(); s.rst_n = 0; s.ex_mem_load = 1; s.ex_rd = 5; s.id_rs = 5;
    s.mem_reg_write = 1; s.mem_rd = 3; s.ex_rs = 3;
    step(s, C_RST, C_RST, "reset");
    step(idle(), C_RUN, C_RUN, "post_reset");

    s = idle(); s.ex_mem_load = 1; s.ex_rd = 5; s.id_rs = 5;
    step(s, C_LU, C_LU, "lu_rs");
    step(idle(), C_RUN, C_LU, "lu_rs_2");
    step(idle(), C_RUN, C_RUN, "lu_rs_done");

    s = idle(); s.ex_mem_load = 1; s.ex_rd = 6; s.id_rt = 6;
    step(s, C_RUN, C_RUN, "rt_unused");
    s.id_uses_rt = 1;
    step(s, C_LU, C_LU, "lu_rt");
    step(idle(), C_RUN, C_LU, "lu_rt_2");

    s = idle(); s.ex_mem_load = 1; s.ex_rd = 0; s.id_rs = 0; s.id_uses_rt = 1;
    step(s, C_RUN, C_RUN, "r0_no_stall");

    s = idle(); s.mem_reg_write = 1; s.mem_rd = 0; s.wb_reg_write = 1; s.wb_rd = 0;
    step(s, C_RUN, C_RUN, "r0_no_fwd");
    s = idle(); s.mem_reg_write = 1; s.mem_rd = 7; s.wb_reg_write = 1; s.wb_rd = 7;
    s.ex_rs = 7; s.ex_rt = 9;
    step(s, C_RUN | FA_M, C_RUN | FA_M, "fwd_mem_prio");
    s.mem_reg_write = 0;
    step(s, C_RUN | FA_W, C_RUN | FA_W, "fwd_wb");
    s.mem_reg_write = 1; s.ex_rt = 7; s.ex_rs = 2;
    step(s, C_RUN | FB_M, C_RUN | FB_M, "fwd_b_mem");

    s = idle(); s.branch_taken = 1;
    step(s, C_BR, C_BR, "branch");

    s = idle(); s.mem_access = 1; s.dmem_ready = 0; s.branch_taken = 1;
    step(s, C_FRZ, C_FRZ, "wait_br");
    s.branch_taken = 0;
    step(s, C_FRZ, C_FRZ, "wait_2");
    step(s, C_FRZ, C_FRZ, "wait_3");
    s.dmem_ready = 1; s.branch_taken = 1;
    step(s, C_BR, C_BR, "wait_exit_br");
    step(idle(), C_RUN, C_RUN, "after_wait");

    s = idle(); s.ex_mem_load = 1; s.ex_rd = 4; s.id_rs = 4;
    step(s, C_LU, C_LU, "lu_then_wait");
    s = idle(); s.mem_access = 1; s.dmem_ready = 0;
    step(s, C_FRZ, C_FRZ, "stall_to_wait");
    s.dmem_ready = 1;
    step(s, C_RUN, C_RUN, "wait_release");

    s = idle(); s.ex_mem_load = 1; s.ex_rd = 8; s.id_rs = 8;
    step(s, C_LU, C_LU, "lu_pre_reset");
    s = idle(); s.rst_n = 0;
    step(s, C_RST, C_RST, "reset_in_stall");
    step(idle(), C_RUN, C_RUN, "after_reset");

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage MIPS pipeline. Sits beside the ID/EX register and the EX-stage forwarding muxes. Detects load-use hazards and inserts bubbles. Freezes the pipeline while data memory is busy, and flushes IF/ID and ID/EX on a taken branch. Also produces the per-operand forwarding selects for the EX stage, with register 0 never forwarded.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard. Legal values are 1 and 2.
- STALL_CNT_W, 16: width of the statistics counters. Used only with HAZARD_STATS_EN.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs  in  5  rs of the instruction in ID
- id_rt  in  5  rt of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type or store)
- ex_rs  in  5  rs of the instruction in EX
- ex_rt  in  5  rt of the instruction in EX
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_load  in  1  instruction in EX is a load
- mem_rd  in  5  destination register in MEM
- mem_reg_write  in  1  instruction in MEM writes a register
- mem_access  in  1  instruction in MEM is a load or store
- dmem_ready  in  1  data memory completes this cycle
- wb_rd  in  5  destination register in WB
- wb_reg_write  in  1  instruction in WB writes a register
- branch_taken  in  1  branch resolved taken in EX
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  clear IF/ID to a NOP
- idex_bubble  out  1  load a NOP into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- fwd_a  out  2  EX operand A select: 00 = register file, 01 = WB, 10 = MEM
- fwd_b  out  2  EX operand B select, same encoding as fwd_a
- stall_cycles  out  STALL_CNT_W  statistics: count of stall cycles
- flush_count  out  STALL_CNT_W  statistics: count of flushes

## Operation
States: RUN, STALL, MEM_WAIT. Control outputs are a Mealy function of the state and the inputs.

Definitions used below:
- wait = mem_access & ~dmem_ready
- lu = ex_mem_load & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt))

RUN state. Conditions are evaluated in priority order:
1. wait: pipe_freeze=1, pc_we=0, ifid_we=0. Next state MEM_WAIT. A branch_taken in the same cycle is ignored; it is re-seen on exit.
2. branch_taken: ifid_flush=1, idex_bubble=1, pc_we=1. Stay in RUN. flush_count increments.
3. lu: pc_we=0, ifid_we=0, idex_bubble=1. Next state is STALL if LOAD_STALL_CYCLES=2, otherwise RUN.
4. Otherwise: pc_we=1, ifid_we=1, all other control outputs 0.

STALL state (exactly one cycle):
- Outputs are the same as a lu cycle.
- Hazard detection is suppressed.
- Next state RUN, unless wait, which takes the state to MEM_WAIT with freeze outputs.

MEM_WAIT state:
- pipe_freeze=1, pc_we=0, ifid_we=0, idex_bubble=0, ifid_flush=0.
- Stays in MEM_WAIT while dmem_ready=0.
- On dmem_ready=1, outputs are evaluated as in RUN in that same cycle and the state becomes RUN.

Forwarding (fwd_a from ex_rs; fwd_b identically from ex_rt):
- 10 if mem_reg_write & mem_rd != 0 & mem_rd == ex_rs.
- Else 01 if wb_reg_write & wb_rd != 0 & wb_rd == ex_rs.
- Else 00.
- MEM always has priority over WB.
- Selects are purely combinational and independent of state.

Statistics, with HAZARD_STATS_EN:
- stall_cycles increments in every cycle where pc_we=0.
- flush_count increments on every branch flush.
- Both counters saturate at all-ones.

## Timing
- Reset (rst_n low, asynchronous):
  - State is RUN and both counters are 0.
  - While rst_n is low, outputs are forced: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0, fwd_a=fwd_b=00.
- Normal operation resumes in the first clock edge after rst_n deasserts.
- Reset asserted in STALL or MEM_WAIT aborts the sequence immediately. No stall is carried over after reset.
- A load-use hazard detected in cycle N stalls cycles N..N+LOAD_STALL_CYCLES-1. The dependent instruction enters EX in cycle N+LOAD_STALL_CYCLES.
- Branch flush takes exactly one cycle, the same cycle branch_taken is high.
- Combinational latency from inputs to outputs is 0 cycles.

## Configuration
- HAZARD_STATS_EN defined: stall_cycles and flush_count are live counters.
- HAZARD_STATS_EN undefined: both ports are tied to 0, no counter flops exist, and control behaviour is identical.

## Test plan
- Hazard with LOAD_STALL_CYCLES=1: ex_mem_load=1, ex_rd=5, id_rs=5 -> pc_we=0, ifid_we=0, idex_bubble=1 for 1 cycle, then RUN with pc_we=1.
- Hazard with LOAD_STALL_CYCLES=2: same stimulus -> 2 bubble cycles, then RUN.
- Register 0 is never forwarded or stalled on:
  - ex_rd=0 with ex_mem_load=1 and id_rs=0 -> no stall.
  - mem_rd=0, mem_reg_write=1, ex_rs=0 -> fwd_a=00.
- Forwarding priority: mem_rd=wb_rd=7, both reg_write=1, ex_rs=7, ex_rt=9 -> fwd_a=10, fwd_b=00. With mem_reg_write=0 -> fwd_a=01.
- Memory wait overrides branch: mem_access=1, dmem_ready=0 for 3 cycles, with branch_taken=1 in the first cycle -> pipe_freeze=1 for 3 cycles and no flush. In the cycle dmem_ready=1 with branch_taken still 1 -> ifid_flush=1 and idex_bubble=1 in that same cycle.
- Reset mid-sequence: enter STALL (LOAD_STALL_CYCLES=2), assert rst_n low -> forced reset outputs. After release -> pc_we=1 with no residual stall. Counters read 0 with HAZARD_STATS_EN.
